// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline types: FSM states, register index type,
// opcode constants and the load-use hazard rule.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  typedef logic [4:0] regidx_t;

  localparam regidx_t    X0           = 5'd0;
  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  // Store data (rs2) is forwarded in MEM, so stores never stall on rs2.
  function automatic logic is_load_use(
    input logic    memread,
    input regidx_t rd,
    input regidx_t rs1,
    input regidx_t rs2,
    input logic    store
  );
    return memread && (rd != X0) &&
           ((rd == rs1) || ((rd == rs2) && !store));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      value <= '0;
    else if (inc && (value != '1))
      value <= value + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush scheduler with memory-wait
// watchdog and performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       rs1_if,
  input  logic [4:0]       rs2_if,
  input  logic             memwrite_if,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken_ex,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_flush,
  output logic             ctrl_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WW-1:0] W_LAST = WW'(MEM_TIMEOUT - 1);

  state_t        state;
  logic [WW-1:0] wait_cnt;

  logic load_use;
  logic halt;
  logic frz;
  logic br;
  logic lu;

  assign load_use = is_load_use(ex_memread, ex_rd,
                                rs1_if, rs2_if,
                                memwrite_if);

  // Mutually exclusive action selects in priority order.
  assign halt = (state == ERROR);
  assign frz  = (state == MEM_WAIT) ||
                ((state == RUN) && mem_req && !mem_ready);
  assign br   = !halt && !frz && branch_taken_ex;
  assign lu   = !halt && !frz && !branch_taken_ex
                && load_use;

  assign ctrl_error = halt;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    memwb_flush = 1'b0;
    unique case (1'b1)
      halt, frz: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_flush = 1'b1;
      end
      br: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      lu: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= WW'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready || !mem_req) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == W_LAST) begin
            state <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        ERROR: ;
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (!pc_en),
    .value (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (br),
    .value (flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard cases
// then random traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int TMO   = 64;
  localparam int MAXC  = (1 << CNT_W) - 1;

  // {pc_en,ifid_en,ifid_flush,idex_en,
  //  idex_flush,exmem_en,memwb_flush,ctrl_error}
  localparam logic [7:0] O_DEF = 8'b11010100;
  localparam logic [7:0] O_LU  = 8'b00011100;
  localparam logic [7:0] O_BR  = 8'b11111100;
  localparam logic [7:0] O_FRZ = 8'b00000010;
  localparam logic [7:0] O_ERR = 8'b00000011;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [4:0] rs1_if = '0;
  logic [4:0] rs2_if = '0;
  logic [4:0] ex_rd = '0;
  logic memwrite_if = 1'b0;
  logic ex_memread = 1'b0;
  logic branch_taken_ex = 1'b0;
  logic mem_req = 1'b0;
  logic mem_ready = 1'b0;

  logic pc_en, ifid_en, ifid_flush, idex_en;
  logic idex_flush, exmem_en, memwb_flush;
  logic ctrl_error;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [7:0] outs;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_wait;
  bit m_err;
  int m_waited;
  int m_stalls;
  int m_flushes;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(TMO),
    .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .rs1_if         (rs1_if),
    .rs2_if         (rs2_if),
    .memwrite_if    (memwrite_if),
    .ex_memread     (ex_memread),
    .ex_rd          (ex_rd),
    .branch_taken_ex(branch_taken_ex),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .ifid_flush     (ifid_flush),
    .idex_en        (idex_en),
    .idex_flush     (idex_flush),
    .exmem_en       (exmem_en),
    .memwb_flush    (memwb_flush),
    .ctrl_error     (ctrl_error),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  assign outs = {pc_en, ifid_en, ifid_flush, idex_en,
                 idex_flush, exmem_en, memwb_flush,
                 ctrl_error};

  always #5 clk = ~clk;

  function automatic logic [7:0] expect_outs();
    bit hz;
    hz = ex_memread && ex_rd != 0 &&
         (ex_rd == rs1_if ||
          (ex_rd == rs2_if && !memwrite_if));
    if (m_err) return O_ERR;
    if (m_wait || (mem_req && !mem_ready)) return O_FRZ;
    if (branch_taken_ex) return O_BR;
    if (hz) return O_LU;
    return O_DEF;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < MAXC) ? v + 1 : MAXC;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0;
    m_err = 0;
    m_waited = 0;
    m_stalls = 0;
    m_flushes = 0;
  endtask

  task automatic set_in(input int r1, input int r2,
                        input bit mw, input bit mr,
                        input int rd, input bit br,
                        input bit req, input bit rdy);
    rs1_if = 5'(r1);
    rs2_if = 5'(r2);
    memwrite_if = mw;
    ex_memread = mr;
    ex_rd = 5'(rd);
    branch_taken_ex = br;
    mem_req = req;
    mem_ready = rdy;
  endtask

  task automatic step(input string tag);
    logic [7:0] e;
    @(negedge clk);
    e = expect_outs();
    chk(tag, 32'(outs), 32'(e));
    chk({tag, "_stalls"}, 32'(stall_cycles), 32'(m_stalls));
    chk({tag, "_flushes"}, 32'(flush_count), 32'(m_flushes));
    @(posedge clk);
    if (!e[7]) m_stalls = sat_inc(m_stalls);
    if (e == O_BR) m_flushes = sat_inc(m_flushes);
    if (!m_err) begin
      if (m_wait) begin
        if (mem_ready || !mem_req) begin
          m_wait = 0;
        end else if (m_waited + 1 == TMO) begin
          m_err = 1;
          m_wait = 0;
        end else begin
          m_waited++;
        end
      end else if (mem_req && !mem_ready) begin
        m_wait = 1;
        m_waited = 1;
      end
    end
    #1;
  endtask

  // Async reset applied mid-cycle, checked while held.
  task automatic do_reset(input string tag);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    model_reset();
    #2;
    chk({tag, "_outs"}, 32'(outs), 32'(O_DEF));
    chk({tag, "_stalls"}, 32'(stall_cycles), 0);
    chk({tag, "_flushes"}, 32'(flush_count), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #3;
    chk("rst_outs", 32'(outs), 32'(O_DEF));
    chk("rst_stalls", 32'(stall_cycles), 0);
    chk("rst_flushes", 32'(flush_count), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    set_in(5, 7, 0, 1, 5, 0, 0, 0);
    step("lu_rs1");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("lu_after");
    chk("lu_stall_one", 32'(stall_cycles), 1);

    set_in(2, 5, 1, 1, 5, 0, 0, 0);
    step("store_rs2");
    set_in(0, 0, 0, 1, 0, 0, 0, 0);
    step("x0_dest");

    set_in(5, 0, 0, 1, 5, 1, 0, 0);
    step("br_over_lu");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("br_after");
    chk("br_flush_one", 32'(flush_count), 1);

    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      step("mem_busy");
    end
    set_in(0, 0, 0, 0, 0, 1, 1, 1);
    step("mem_done");
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    step("mem_release");
    chk("mem_stall_total", 32'(stall_cycles), 5);

    do_reset("rst2");
    for (int i = 0; i < TMO; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      step("tmo_wait");
    end
    set_in(0, 0, 0, 0, 0, 1, 0, 1);
    step("err_hold");
    step("err_sticky");
    chk("err_flag", 32'(ctrl_error), 1);
    chk("stall_sat", 32'(stall_cycles), 32'(MAXC));
    do_reset("rst_err");
    chk("err_cleared", 32'(ctrl_error), 0);

    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step("abort_enter");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("abort_frz");
    step("abort_run");

    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step("midrst_a");
    step("midrst_b");
    do_reset("rst_mid");
    step("after_midrst");

    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) do_reset("rst_rand");
      set_in($urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             $urandom_range(0, 3),
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0,
             1'($urandom_range(0, 1)));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
